// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_unit_pkg;

    localparam int unsigned WORD_LEN = 16;
    localparam int unsigned ADDR_LEN = 16;
    localparam int unsigned ENTRY_W  = ADDR_LEN + WORD_LEN;

    localparam logic [WORD_LEN-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [WORD_LEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with single-cycle flush.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic [CntW-1:0]    count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order requests and buffers responses.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter logic [ADDR_LEN-1:0] RESET_PC   = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [WORD_LEN-1:0] imem_rsp_data,
    input  logic                hazard_detected,
    input  logic                brTaken,
    input  logic [ADDR_LEN-1:0] br_target,
    output logic                instr_valid,
    output logic [WORD_LEN-1:0] instruction,
    output logic [ADDR_LEN-1:0] pc_out
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [ADDR_LEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0]     outstanding_q, outstanding_d;
    logic [CntW-1:0]     discard_q, discard_d;

    logic               fifo_valid;
    logic [CntW-1:0]    fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;

    logic [CntW-1:0] live;
    logic [CntW:0]   committed;
    logic            credit;
    logic            req_fire;
    logic            rsp_fire;
    logic            keep_rsp;
    logic            pop;

    // Slots already promised: buffered entries plus responses that will be kept.
    assign live      = outstanding_q - discard_q;
    assign committed = {1'b0, fifo_count} + {1'b0, live};
    assign credit    = committed < DepthW;

    assign imem_req_valid = credit && !brTaken && !rst;
    assign imem_addr      = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid;
    assign keep_rsp = rsp_fire && (discard_q == '0) && !brTaken;
    assign pop      = fifo_valid && !hazard_detected && !brTaken;

    // Kept responses arrive in issue order, so a running counter supplies the pc tag.
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_fire);
        discard_d     = discard_q;
        if (brTaken) begin
            pc_d      = br_target;
            rsp_pc_d  = br_target;
            discard_d = outstanding_q - CntW'(rsp_fire);
        end else begin
            if (req_fire) pc_d = pc_q + 1'b1;
            if (keep_rsp) rsp_pc_d = rsp_pc_q + 1'b1;
            if (rsp_fire && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (brTaken),
        .push_i  (keep_rsp),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .valid_o (fifo_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign head        = fifo_rdata;
    assign instr_valid = fifo_valid;
    assign instruction = fifo_valid ? head.instr : NOP_INSTR;
    assign pc_out      = fifo_valid ? head.pc : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order variable-latency memory model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        hazard_detected;
    logic        brTaken;
    logic [15:0] br_target;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] pc_out;

    if_fetch_unit #(
        .FIFO_DEPTH (4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .hazard_detected (hazard_detected),
        .brTaken         (brTaken),
        .br_target       (br_target),
        .instr_valid     (instr_valid),
        .instruction     (instruction),
        .pc_out          (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int last_due = -100;
    int accepted = 0;
    int popped = 0;

    logic [15:0] exp_q [$];
    logic [15:0] maddr_q [$];
    int          due_q [$];
    logic [15:0] exp_req_addr;

    logic        s_req_valid;
    logic        s_valid;
    logic [15:0] s_pc;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_expected(input logic [15:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(start + 16'(i));
        exp_req_addr = start;
    endtask

    // One clock cycle: drive memory response, sample, score, advance to next negedge.
    task automatic tick();
        int due;
        logic [15:0] e;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(maddr_q[0]);
            void'(due_q.pop_front());
            void'(maddr_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0000;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_valid     = instr_valid;
        s_pc        = pc_out;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", 32'(imem_addr), 32'(exp_req_addr));
            exp_req_addr = exp_req_addr + 16'd1;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
            maddr_q.push_back(imem_addr);
            accepted++;
        end
        if (brTaken) begin
            check("req_during_redirect", 32'(imem_req_valid), 32'd0);
            fill_expected(br_target);
        end else if (instr_valid && !hazard_detected) begin
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("head_pc", 32'(pc_out), 32'(e));
                check("head_instr", 32'(instruction), 32'(mem_data(e)));
            end
            popped++;
        end else if (!instr_valid) begin
            check("idle_instr", 32'(instruction), 32'h0);
            check("idle_pc", 32'(pc_out), 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instruction", 32'(instruction), 32'h0);
        check("rst_pc_out", 32'(pc_out), 32'h0);
        check("rst_imem_addr", 32'(imem_addr), 32'h0);
        due_q.delete();
        maddr_q.delete();
        last_due = -100;
        fill_expected(16'h0000);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int hold_pc;
        int max_if;
        int saw_drop;
        int p0;
        int a0;
        int n;

        rst             = 1'b0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 16'h0000;
        hazard_detected = 1'b0;
        brTaken         = 1'b0;
        br_target       = 16'h0000;

        // Reset and streaming at L=1.
        pulse_reset();
        tick();
        check("first_req_valid", 32'(s_req_valid), 32'd1);
        check("c0_valid", 32'(s_valid), 32'd0);
        tick();
        check("c1_valid", 32'(s_valid), 32'd0);
        tick();
        check("c2_valid", 32'(s_valid), 32'd1);
        check("c2_pc", 32'(s_pc), 32'h0);
        p0 = popped;
        repeat (10) tick();
        check("throughput", 32'(popped - p0), 32'd10);

        // Decode stall for 5 cycles.
        hazard_detected = 1'b1;
        tick();
        hold_pc  = int'(s_pc);
        max_if   = accepted - popped;
        saw_drop = 0;
        repeat (4) begin
            tick();
            check("hazard_hold", 32'(s_pc), 32'(hold_pc));
            if (accepted - popped > max_if) max_if = accepted - popped;
            if (!s_req_valid) saw_drop = 1;
        end
        check("inflight_max", 32'(max_if), 32'd4);
        check("req_valid_dropped", 32'(saw_drop), 32'd1);
        hazard_detected = 1'b0;
        repeat (10) tick();

        // Redirect with 3 outstanding at L=3; first response coincides with brTaken.
        pulse_reset();
        lat_min = 3;
        lat_max = 3;
        a0 = accepted;
        repeat (3) tick();
        check("three_outstanding", 32'(accepted - a0), 32'd3);
        brTaken   = 1'b1;
        br_target = 16'h0040;
        tick();
        brTaken = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_valid && n < 20);
        check("redirect_latency_l3", 32'(n), 32'd5);
        check("redirect_pc", 32'(s_pc), 32'h0040);
        repeat (10) tick();

        // Drain, then redirect near the top of the address space at L=1.
        imem_req_ready = 1'b0;
        repeat (6) tick();
        imem_req_ready = 1'b1;
        lat_min   = 1;
        lat_max   = 1;
        brTaken   = 1'b1;
        br_target = 16'hFFFE;
        tick();
        brTaken = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_valid && n < 20);
        check("redirect_latency_l1", 32'(n), 32'd3);
        check("wrap_first_pc", 32'(s_pc), 32'hFFFE);
        repeat (6) tick();

        // Random ready, latency, stalls and redirects with a reset pulse mid-stream.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 120; i++) begin
            if (i == 60) begin
                hazard_detected = 1'b0;
                brTaken         = 1'b0;
                pulse_reset();
            end
            imem_req_ready  = ($urandom_range(3, 0) != 0);
            hazard_detected = ($urandom_range(4, 0) == 0);
            brTaken         = ($urandom_range(19, 0) == 0);
            br_target       = 16'($urandom);
            tick();
        end
        brTaken         = 1'b0;
        hazard_detected = 1'b0;
        imem_req_ready  = 1'b1;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
